// File: rtl/dadda_seq_mult_ctrl_pkg.sv
// Shared types and helpers for the sequential 4:2-compressor multiplier.
package dadda_seq_mult_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_FINAL  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Row counter width: enough to count WIDTH/2 reduce steps plus one.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width / 2) + 1;
    endfunction

endpackage

// File: rtl/dadda_seq_mult_ctrl_if.sv
// Operand/product valid-ready bus for the sequential multiplier.
interface dadda_seq_mult_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/dadda_seq_mult_ctrl_comp42_row.sv
// One row of N chained 4:2 compressor cells, purely combinational.
module comp42_row #(
    parameter int unsigned N = 16
) (
    input  logic [N-1:0] x0,
    input  logic [N-1:0] x1,
    input  logic [N-1:0] x2,
    input  logic [N-1:0] x3,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry,
    output logic         cout
);
    // chain[i] is the lateral carry entering cell i; it never depends on chain[i] itself.
    logic [N:0] chain;

    assign chain[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_cell
        logic s1;
        // First full adder on x0..x2, second merges x3 with the incoming lateral carry.
        assign s1          = x0[i] ^ x1[i] ^ x2[i];
        assign chain[i+1]  = (x0[i] & x1[i]) | (x0[i] & x2[i]) | (x1[i] & x2[i]);
        assign sum[i]      = s1 ^ x3[i] ^ chain[i];
        assign carry[i]    = (s1 & x3[i]) | (s1 & chain[i]) | (x3[i] & chain[i]);
    end

    assign cout = chain[N];
endmodule

// File: rtl/dadda_seq_mult_ctrl.sv
// Multicycle unsigned multiplier: two partial-product rows folded per cycle, then one CPA.
module dadda_seq_mult_ctrl
    import dadda_seq_mult_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dadda_seq_mult_ctrl_if.slave bus
);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CW    = cnt_width(WIDTH);
    localparam int unsigned STEPS = WIDTH / 2;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [PW-1:0]   sum_q, carry_q, product_q;
    logic            out_valid_q;

    logic            in_ready_c, accept_c;
    logic [PW-1:0]   pp0_c, pp1_c;
    logic [PW-1:0]   row_sum, row_carry;
    logic            row_cout;
    logic            unused_bits;

    // Handshake: a DONE slot frees up in the same cycle the product is taken.
    assign in_ready_c = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign accept_c   = bus.in_valid && in_ready_c;

    // a_sh/b_sh are pre-shifted each step so bits 0/1 of b_sh select pp_(2*cnt), pp_(2*cnt+1).
    assign pp0_c = b_sh_q[0] ? a_sh_q : '0;
    assign pp1_c = b_sh_q[1] ? PW'(a_sh_q << 1) : '0;

    comp42_row #(.N(PW)) u_row (
        .x0    (sum_q),
        .x1    (carry_q),
        .x2    (pp0_c),
        .x3    (pp1_c),
        .cin   (1'b0),
        .sum   (row_sum),
        .carry (row_carry),
        .cout  (row_cout)
    );

    // Row cout and the carry bit shifted past the top are weight >= 2^PW; product fits regardless.
    assign unused_bits = row_cout ^ row_carry[PW-1];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept_c) state_d = ST_REDUCE;
            ST_REDUCE: if (cnt_q == CW'(STEPS - 1)) state_d = ST_FINAL;
            ST_FINAL:  state_d = ST_DONE;
            ST_DONE: begin
                if (accept_c)           state_d = ST_REDUCE;
                else if (bus.out_ready) state_d = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Operand load, row accumulation, final add and output hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_q       <= '0;
            carry_q     <= '0;
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept_c) begin
                a_sh_q  <= PW'(bus.a);
                b_sh_q  <= bus.b;
                sum_q   <= '0;
                carry_q <= '0;
                cnt_q   <= '0;
            end
            unique case (state_q)
                ST_REDUCE: begin
                    sum_q   <= row_sum;
                    carry_q <= PW'(row_carry << 1);
                    a_sh_q  <= PW'(a_sh_q << 2);
                    b_sh_q  <= WIDTH'(b_sh_q >> 2);
                    cnt_q   <= cnt_q + CW'(1);
                end
                ST_FINAL: begin
                    product_q   <= sum_q + carry_q;
                    out_valid_q <= 1'b1;
                end
                ST_DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = (state_q == ST_REDUCE) || (state_q == ST_FINAL);
endmodule
